// File: rtl/difftest_veccsr_arbiter_pkg.sv
// Shared types and constants for the vector-CSR difftest arbiter.
// A snapshot is seven 64-bit CSR fields plus the originating core id.
package difftest_veccsr_pkg;

   localparam int FIELD_W  = 64;
   localparam int SNAP_W   = 448;
   localparam int COREID_W = 8;

   localparam int OFF_VLENB  = 0;
   localparam int OFF_VTYPE  = 64;
   localparam int OFF_VL     = 128;
   localparam int OFF_VCSR   = 192;
   localparam int OFF_VXRM   = 256;
   localparam int OFF_VXSAT  = 320;
   localparam int OFF_VSTART = 384;

   typedef struct packed {
      logic [FIELD_W-1:0]  vstart;
      logic [FIELD_W-1:0]  vxsat;
      logic [FIELD_W-1:0]  vxrm;
      logic [FIELD_W-1:0]  vcsr;
      logic [FIELD_W-1:0]  vl;
      logic [FIELD_W-1:0]  vtype;
      logic [FIELD_W-1:0]  vlenb;
      logic [COREID_W-1:0] coreid;
   } veccsr_snap_t;

   function automatic veccsr_snap_t unpack_snap(input logic [SNAP_W-1:0] raw,
                                                input logic [COREID_W-1:0] coreid);
      veccsr_snap_t s;
      s.vstart = raw[OFF_VSTART +: FIELD_W];
      s.vxsat  = raw[OFF_VXSAT  +: FIELD_W];
      s.vxrm   = raw[OFF_VXRM   +: FIELD_W];
      s.vcsr   = raw[OFF_VCSR   +: FIELD_W];
      s.vl     = raw[OFF_VL     +: FIELD_W];
      s.vtype  = raw[OFF_VTYPE  +: FIELD_W];
      s.vlenb  = raw[OFF_VLENB  +: FIELD_W];
      s.coreid = coreid;
      return s;
   endfunction

endpackage

// File: rtl/difftest_veccsr_arbiter_if.sv
// Requester-side push buses plus the sink-side snapshot port of the arbiter.
// master = commit logic / sink environment, slave = the arbiter itself.
interface difftest_veccsr_arbiter_if #(parameter int NCORE = 2);
   import difftest_veccsr_pkg::*;

   localparam int SRC_W = (NCORE > 1) ? $clog2(NCORE) : 1;

   logic [NCORE-1:0]          in_valid;
   logic [NCORE-1:0]          in_ready;
   logic [NCORE*SNAP_W-1:0]   in_snap;
   logic [NCORE*COREID_W-1:0] in_coreid;
   logic                      pause;

   logic                      out_enable;
   logic [FIELD_W-1:0]        out_vstart;
   logic [FIELD_W-1:0]        out_vxsat;
   logic [FIELD_W-1:0]        out_vxrm;
   logic [FIELD_W-1:0]        out_vcsr;
   logic [FIELD_W-1:0]        out_vl;
   logic [FIELD_W-1:0]        out_vtype;
   logic [FIELD_W-1:0]        out_vlenb;
   logic [COREID_W-1:0]       out_coreid;
   logic [SRC_W-1:0]          out_src;

   modport master (
      output in_valid, in_snap, in_coreid, pause,
      input  in_ready,
      input  out_enable, out_vstart, out_vxsat, out_vxrm, out_vcsr,
      input  out_vl, out_vtype, out_vlenb, out_coreid, out_src
   );

   modport slave (
      input  in_valid, in_snap, in_coreid, pause,
      output in_ready,
      output out_enable, out_vstart, out_vxsat, out_vxrm, out_vcsr,
      output out_vl, out_vtype, out_vlenb, out_coreid, out_src
   );

endinterface

// File: rtl/difftest_veccsr_arbiter_fifo.sv
// Per-requester snapshot FIFO with registered occupancy; push and pop may
// coincide, and full/empty decode from registers only.
module difftest_veccsr_fifo
   import difftest_veccsr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  veccsr_snap_t push_data,
   output veccsr_snap_t head,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   veccsr_snap_t    mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic            do_push_s;
   logic            do_pop_s;

   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == (AW+1)'(0));
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r];

   // Storage write; slot contents only matter once count_r covers them.
   always_ff @(posedge clock) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy; reset empties the FIFO and drops its contents.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/difftest_veccsr_arbiter.sv
// Round-robin arbiter sharing one vector-CSR difftest sink between NCORE
// commit-side requesters, one registered delivery per cycle.
module difftest_veccsr_arbiter
   import difftest_veccsr_pkg::*;
#(
   parameter int NCORE = 2,
   parameter int DEPTH = 2
) (
   input logic                      clock,
   input logic                      reset,
   difftest_veccsr_arbiter_if.slave bus
);

   localparam int SRC_W = (NCORE > 1) ? $clog2(NCORE) : 1;

   logic [NCORE-1:0] full_s;
   logic [NCORE-1:0] empty_s;
   logic [NCORE-1:0] req_s;
   logic [NCORE-1:0] pop_s;
   logic             any_req_s;
   logic [SRC_W-1:0] win_s;
   logic [SRC_W-1:0] rr_next_s;
   logic [SRC_W-1:0] rr_r;
   logic [SRC_W-1:0] src_r;
   logic             enable_r;
   veccsr_snap_t     head_s [NCORE];
   veccsr_snap_t     win_head_s;
   veccsr_snap_t     out_r;

   for (genvar g = 0; g < NCORE; g++) begin : g_req
      veccsr_snap_t push_data_s;

      assign push_data_s = unpack_snap(bus.in_snap[g*SNAP_W +: SNAP_W],
                                       bus.in_coreid[g*COREID_W +: COREID_W]);

      difftest_veccsr_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (bus.in_valid[g]),
         .pop       (pop_s[g]),
         .push_data (push_data_s),
         .head      (head_s[g]),
         .full      (full_s[g]),
         .empty     (empty_s[g])
      );
   end

   assign bus.in_ready = ~full_s;

   // Winner search: first non-empty requester at or after rr_r, wrapping.
   always_comb begin : p_arb
      logic             found_v;
      logic [SRC_W:0]   sum_v;
      logic [SRC_W-1:0] idx_v;
      req_s     = ~empty_s & {NCORE{~bus.pause}};
      any_req_s = |req_s;
      found_v   = 1'b0;
      sum_v     = (SRC_W+1)'(0);
      idx_v     = SRC_W'(0);
      win_s     = SRC_W'(0);
      pop_s     = NCORE'(0);
      for (int k = 0; k < NCORE; k++) begin
         sum_v = {1'b0, rr_r} + (SRC_W+1)'(k);
         if (sum_v >= (SRC_W+1)'(NCORE)) begin
            sum_v = sum_v - (SRC_W+1)'(NCORE);
         end else begin
            sum_v = sum_v;
         end
         idx_v = sum_v[SRC_W-1:0];
         if (!found_v && req_s[idx_v]) begin
            found_v = 1'b1;
            win_s   = idx_v;
         end else begin
            found_v = found_v;
         end
      end
      if (found_v) begin
         pop_s[win_s] = 1'b1;
      end else begin
         pop_s = NCORE'(0);
      end
      rr_next_s = (win_s == SRC_W'(NCORE - 1)) ? SRC_W'(0) : win_s + SRC_W'(1);
   end

   // Head mux driven by the one-hot pop vector.
   always_comb begin
      win_head_s = head_s[0];
      for (int i = 0; i < NCORE; i++) begin
         win_head_s = pop_s[i] ? head_s[i] : win_head_s;
      end
   end

   // Output registers and round-robin pointer; data holds when nothing pops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enable_r <= 1'b0;
         out_r    <= '0;
         src_r    <= SRC_W'(0);
         rr_r     <= SRC_W'(0);
      end else if (any_req_s) begin
         enable_r <= 1'b1;
         out_r    <= win_head_s;
         src_r    <= win_s;
         rr_r     <= rr_next_s;
      end else begin
         enable_r <= 1'b0;
      end
   end

   assign bus.out_enable = enable_r;
   assign bus.out_vstart = out_r.vstart;
   assign bus.out_vxsat  = out_r.vxsat;
   assign bus.out_vxrm   = out_r.vxrm;
   assign bus.out_vcsr   = out_r.vcsr;
   assign bus.out_vl     = out_r.vl;
   assign bus.out_vtype  = out_r.vtype;
   assign bus.out_vlenb  = out_r.vlenb;
   assign bus.out_coreid = out_r.coreid;
   assign bus.out_src    = src_r;

endmodule

// File: tb/tb_difftest_veccsr_arbiter.sv
// Scoreboard bench for difftest_veccsr_arbiter (NCORE=3, DEPTH=2): a
// queue-based reference model predicts deliveries, a monitor compares them.
module tb_difftest_veccsr_arbiter;

   localparam int NC    = 3;
   localparam int DEPTH = 2;
   localparam int SW    = 448;

   typedef struct {
      logic [SW-1:0] snap;
      logic [7:0]    id;
      int            src;
   } item_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   difftest_veccsr_arbiter_if #(.NCORE(NC)) bus ();

   difftest_veccsr_arbiter #(.NCORE(NC), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // reference model state
   item_t         mq [NC][$];
   item_t         exp_q [$];
   item_t         last_m;
   int            rr_m = 0;
   bit            exp_en_m = 1'b0;
   bit [NC-1:0]   ready_m = '1;

   // stimulus state
   logic [SW-1:0] cur_snap [NC];
   logic [7:0]    cur_id [NC];
   int            pend [NC];
   bit            pause_force = 1'b0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [SW-1:0] rand_snap();
      logic [SW-1:0] s;
      for (int w = 0; w < SW/32; w++) s[w*32 +: 32] = $urandom();
      return s;
   endfunction

   // Reference model: one pop per edge (round robin from rr_m), then accepts.
   initial begin : model
      bit [NC-1:0] acc;
      item_t       e;
      int          c;
      last_m.snap = '0; last_m.id = '0; last_m.src = 0;
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            exp_q.delete();
            last_m.snap = '0; last_m.id = '0; last_m.src = 0;
            rr_m = 0; exp_en_m = 1'b0; ready_m = '1;
         end else begin
            acc = bus.in_valid & ready_m;
            exp_en_m = 1'b0;
            if (!bus.pause) begin
               for (int k = 0; k < NC; k++) begin
                  c = (rr_m + k) % NC;
                  if (!exp_en_m && mq[c].size() > 0) begin
                     e = mq[c].pop_front();
                     exp_q.push_back(e);
                     rr_m = (c + 1) % NC;
                     exp_en_m = 1'b1;
                  end
               end
            end
            for (int i = 0; i < NC; i++) begin
               if (acc[i]) begin
                  e.snap = bus.in_snap[i*SW +: SW];
                  e.id   = bus.in_coreid[i*8 +: 8];
                  e.src  = i;
                  mq[i].push_back(e);
               end
            end
            for (int i = 0; i < NC; i++) ready_m[i] = (mq[i].size() < DEPTH);
         end
      end
   end

   // Monitor: compares enable, ready and delivered/held data every negedge.
   initial begin : monitor
      logic [SW-1:0] act;
      @(negedge reset);
      forever begin
         @(negedge clock);
         chk("out_enable", 512'(bus.out_enable), 512'(exp_en_m));
         chk("in_ready", 512'(bus.in_ready), 512'(ready_m));
         if (bus.out_enable && exp_q.size() > 0) last_m = exp_q.pop_front();
         act = {bus.out_vstart, bus.out_vxsat, bus.out_vxrm, bus.out_vcsr,
                bus.out_vl, bus.out_vtype, bus.out_vlenb};
         chk("out_data", 512'({act, bus.out_coreid, bus.out_src}),
             512'({last_m.snap, last_m.id, 2'(last_m.src)}));
      end
   end

   task automatic drive(input int n, input int refill_pct, input int pause_pct);
      logic [NC-1:0] rdy;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < NC; i++) begin
            if (pend[i] == 0 && refill_pct > 0 && $urandom_range(99) < refill_pct)
               pend[i] = 1 + $urandom_range(3);
            bus.in_valid[i]          = (pend[i] > 0);
            bus.in_snap[i*SW +: SW]  = cur_snap[i];
            bus.in_coreid[i*8 +: 8]  = cur_id[i];
         end
         bus.pause = pause_force || (pause_pct > 0 && $urandom_range(99) < pause_pct);
         rdy = bus.in_ready;
         @(posedge clock); #2;
         for (int i = 0; i < NC; i++) begin
            if (bus.in_valid[i] && rdy[i]) begin
               pend[i]--;
               cur_snap[i] = rand_snap();
               cur_id[i]   = 8'($urandom);
            end
         end
      end
   endtask

   initial begin : stim
      bus.in_valid = '0; bus.in_snap = '0; bus.in_coreid = '0; bus.pause = 1'b0;
      for (int i = 0; i < NC; i++) begin
         pend[i] = 0; cur_snap[i] = rand_snap(); cur_id[i] = 8'(i);
      end
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      drive(2, 0, 0);

      // single push from core0: vl=0x10, vtype=0x8, coreid 0
      cur_snap[0] = '0;
      cur_snap[0][128 +: 64] = 64'h10;
      cur_snap[0][64 +: 64]  = 64'h8;
      cur_id[0] = 8'h00;
      pend[0] = 1;
      drive(6, 0, 0);

      // contention: three snapshots each from core0 and core1
      pend[0] = 3; pend[1] = 3;
      drive(12, 0, 0);

      // backpressure: paused sink, core1 fills its FIFO, then release
      pause_force = 1'b1; pend[1] = 5;
      drive(6, 0, 0);
      pause_force = 1'b0;
      drive(12, 0, 0);

      // pause for three cycles in the middle of a stream
      pend[0] = 4; pend[1] = 4;
      drive(3, 0, 0);
      pause_force = 1'b1;
      drive(3, 0, 0);
      pause_force = 1'b0;
      drive(12, 0, 0);

      // asynchronous reset with both FIFOs full and a delivery in flight
      pause_force = 1'b1; pend[0] = 2; pend[1] = 2;
      drive(4, 0, 0);
      pause_force = 1'b0;
      drive(1, 0, 0);
      #1 reset = 1'b0;
      #1 chk("async_reset_enable", 512'(bus.out_enable), 512'(1'b0));
      for (int i = 0; i < NC; i++) pend[i] = 0;
      drive(2, 0, 0);
      reset = 1'b1;
      drive(6, 0, 0);

      // core2 only: all-ones vstart, vlenb=0x20, rr wraps back to 0
      cur_snap[2] = rand_snap();
      cur_snap[2][384 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
      cur_snap[2][0 +: 64]   = 64'h20;
      cur_id[2] = 8'hA5;
      pend[2] = 3;
      drive(10, 0, 0);
      pend[0] = 1; pend[1] = 1; pend[2] = 1;
      drive(8, 0, 0);

      // randomized traffic, then drain
      drive(400, 30, 20);
      for (int i = 0; i < NC; i++) pend[i] = 0;
      drive(20, 0, 0);
      chk("undelivered_expected", 512'(exp_q.size()), 512'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/difftest_veccsr_arbiter.md
Name: difftest_veccsr_arbiter

Overview:
- Shares one vector-CSR difftest sink (DPI snapshot port: 64-bit vstart, vxsat, vxrm, vcsr, vl, vtype, vlenb; 8-bit coreid; per-cycle enable) between NCORE commit-side requesters.
- Each requester pushes snapshots through a valid/ready handshake into a private FIFO.
- A round-robin scheduler pops one snapshot per cycle into registered outputs that drive the sink.
- Sits between per-core CSR commit logic and the difftest sink in sim builds.

Parameters:
- NCORE, 2, number of requesters (1..8).
- DEPTH, 2, entries per requester FIFO (power of two, >=2).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- in_valid  in  NCORE  per-requester snapshot valid.
- in_ready  out  NCORE  per-requester FIFO not full.
- in_snap  in  NCORE*448  per-requester {vstart,vxsat,vxrm,vcsr,vl,vtype,vlenb}, 64 bits each, vstart in MSBs.
- in_coreid  in  NCORE*8  per-requester core id, captured with the snapshot.
- pause  in  1  1 = no pop this cycle.
- out_enable  out  1  sink enable; one pulse per delivered snapshot.
- out_vstart/out_vxsat/out_vxrm/out_vcsr/out_vl/out_vtype/out_vlenb  out  64 each  delivered fields.
- out_coreid  out  8  delivered core id.
- out_src  out  $clog2(NCORE) (min 1)  index of winning requester.

Behaviour:
- Reset (asynchronous, active-low):
  - All FIFOs empty.
  - out_enable=0; all out_* data=0; out_src=0.
  - Round-robin pointer rr=0.
  - in_ready=all ones once reset deasserts.
  - Reset mid-operation drops all buffered snapshots; no partial output.
- Push:
  - Entry written at the rising edge where in_valid[i]&&in_ready[i].
  - in_ready[i]=!full[i], decoded from registered occupancy only.
  - No combinational path from in_valid or pause to in_ready.
  - No bypass: a snapshot is never eligible in its write cycle.
- Arbitration (combinational each cycle):
  - req[i]=!empty[i]&&!pause.
  - Winner is the first set req searching from index rr upward with wrap-around NCORE-1 -> 0.
- Pop and output:
  - If any req, the winner's FIFO head pops at the edge.
  - At that same edge out_*<=head, out_coreid<=stored coreid, out_src<=winner, out_enable<=1, rr<=(winner+1) mod NCORE.
  - If no req: out_enable<=0, out data holds its last value, rr unchanged.
- Latency: snapshot accepted at edge E is delivered with out_enable high during the cycle after edge E+1, when uncontended and not paused.
- Simultaneous push and pop on the same FIFO: occupancy unchanged, order preserved.
- Full FIFO: in_ready low; it rises in the cycle after the pop.
- Ordering: FIFO order within each requester. Across requesters, no requester with a non-empty FIFO waits more than NCORE-1 grants.
- pause=1: no pop and no rr change; out_enable=0 the next cycle; pushes continue until full.
- Field values pass through bit-exact; the block never interprets or modifies CSR contents.
- Throughput: at most one delivery per cycle, sustained when any FIFO is non-empty.

Decomposition:
- Package difftest_veccsr_pkg holds:
  - veccsr_snap_t: packed struct with seven 64-bit fields plus an 8-bit coreid.
  - SNAP_W=448 and the field offset constants.
- Sub-module difftest_veccsr_fifo:
  - One per requester, DEPTH entries of veccsr_snap_t.
  - push/pop/full/empty interface; registered count; same-cycle push+pop allowed.
- The top level holds the round-robin pointer, winner mux and output registers.

Test Plan:
- Single push: core0 in_valid one cycle at edge E, vl=0x10, vtype=0x8, coreid=0 -> out_enable=1 exactly one cycle after E+1 with out_vl=0x10, out_vtype=0x8, out_src=0; otherwise 0.
- Contention: core0 and core1 each push 3 snapshots back-to-back -> deliveries alternate src 0,1,0,1,0,1; per-core order preserved; out_enable high 6 consecutive cycles.
- Full/backpressure: pause=1, core1 pushes continuously -> in_ready[1] drops after 2 accepts and pushes stall. Release pause -> in_ready[1] rises the cycle after the first pop; no snapshot lost or duplicated.
- Pause mid-stream: pause for 3 cycles during delivery -> out_enable=0 for those 3 cycles, rr unchanged, delivery resumes with the same next winner.
- Reset mid-operation: both FIFOs full, reset=0 asynchronously mid-cycle -> out_enable=0 immediately. After release, no stale snapshot emerges; in_ready=2'b11.
- Wrap/bit-exact: NCORE=3, only core2 active, vstart=0xFFFF_FFFF_FFFF_FFFF, vlenb=0x20 -> all values delivered unchanged, rr wraps to 0, out_coreid equals in_coreid[2].
